// File: rtl/uart_pkg.sv
// ----------------------------------------------------------------------------
// uart_pkg
//   Shared definitions for the UART receive path (and, later, TX/CTS paths).
//   Contents:
//     rx_state_t   - 2-bit receiver FSM state encoding
//     OSR          - oversampling ratio of the baud tick (ticks per bit)
//     DBITS_DEF    - default data bits per frame
//     SB_TICK_DEF  - default ticks spanning the stop bit(s)
//     MID_TICK     - tick index of the middle of a bit (OSR/2 - 1)
//     cnt_width()  - counter width for a modulus, never less than 1 bit
//     max_int()    - larger of two integers, for sizing shared counters
// ----------------------------------------------------------------------------
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } rx_state_t;

  localparam int OSR         = 16;
  localparam int DBITS_DEF   = 8;
  localparam int SB_TICK_DEF = 16;
  localparam int MID_TICK    = OSR / 2 - 1;

  // Bits needed to count 0..n-1; a modulus of 1 or 2 still gets one bit.
  function automatic int cnt_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/uart_rx_if.sv
// ----------------------------------------------------------------------------
// uart_rx_if
//   Byte-delivery bus from the UART receiver to downstream consumer logic.
//   Signals:
//     data_out      [DBITS] last received byte, held until the next frame
//     rx_done_tick  [1]     one-cycle strobe when a frame completes
//     frame_err     [1]     stop-bit sample was 0 for the reported frame
//   Modports:
//     master - the receiver, drives all signals
//     slave  - the consumer, observes all signals
// ----------------------------------------------------------------------------
interface uart_rx_if
  import uart_pkg::*;
#(
  parameter int DBITS = DBITS_DEF
);

  logic [DBITS-1:0] data_out;
  logic             rx_done_tick;
  logic             frame_err;

  modport master (
    output data_out,
    output rx_done_tick,
    output frame_err
  );

  modport slave (
    input data_out,
    input rx_done_tick,
    input frame_err
  );

endinterface

// File: rtl/sync_2ff.sv
// ----------------------------------------------------------------------------
// sync_2ff
//   Two-flop synchronizer for asynchronous inputs with a configurable reset
//   value, so idle-high lines (UART RX, CTS) come out of reset already idle.
//   Ports:
//     clk    in   destination clock
//     rst_n  in   asynchronous active-low reset
//     d      in   asynchronous input  [WIDTH]
//     q      out  synchronized output [WIDTH], two clocks of latency
// ----------------------------------------------------------------------------
module sync_2ff #(
  parameter int               WIDTH     = 1,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= RESET_VAL;
      q    <= RESET_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/uart_rx.sv
// ----------------------------------------------------------------------------
// uart_rx
//   UART receive path for 8N1-style frames, oversampled by the 16x baud tick
//   from baud_rate_generator. Each completed frame is presented on the
//   interface with a one-cycle done strobe and a framing-error flag.
//   Ports:
//     clk_100MHz   in   system clock
//     reset_n      in   asynchronous active-low reset
//     rx           in   asynchronous serial line, idle high
//     sample_tick  in   one-cycle pulse at OSR x baud
//     rx_bus       master modport of uart_rx_if:
//                    data_out     last received byte
//                    rx_done_tick one-cycle pulse per completed frame
//                    frame_err    stop-bit sample was 0 for that frame
// ----------------------------------------------------------------------------
module uart_rx
  import uart_pkg::*;
#(
  parameter int DBITS   = DBITS_DEF,
  parameter int SB_TICK = SB_TICK_DEF
) (
  input  logic       clk_100MHz,
  input  logic       reset_n,
  input  logic       rx,
  input  logic       sample_tick,
  uart_rx_if.master  rx_bus
);

  // One tick counter is shared by the bit-timing states and the stop state,
  // so it must cover whichever span is longer.
  localparam int S_W = max_int(cnt_width(OSR), cnt_width(SB_TICK));
  localparam int N_W = cnt_width(DBITS);

  localparam logic [S_W-1:0] S_ONE       = S_W'(1);
  localparam logic [S_W-1:0] S_MID       = S_W'(MID_TICK);
  localparam logic [S_W-1:0] S_LAST_BIT  = S_W'(OSR - 1);
  localparam logic [S_W-1:0] S_LAST_STOP = S_W'(SB_TICK - 1);
  localparam logic [N_W-1:0] N_ONE       = N_W'(1);
  localparam logic [N_W-1:0] N_LAST      = N_W'(DBITS - 1);

  logic             rx_s;
  rx_state_t        state;
  logic [S_W-1:0]   s;
  logic [N_W-1:0]   n;
  logic [DBITS-1:0] shift;
  logic [DBITS-1:0] data_q;
  logic             done_q;
  logic             ferr_q;

  // The line idles high, so the synchronizer also resets high; otherwise the
  // FSM would see a false start edge right after reset release.
  sync_2ff #(
    .WIDTH     (1),
    .RESET_VAL (1'b1)
  ) u_rx_sync (
    .clk   (clk_100MHz),
    .rst_n (reset_n),
    .d     (rx),
    .q     (rx_s)
  );

  // Receiver FSM. Start-edge detection in IDLE runs every clock so the bit
  // phase is captured as tightly as possible; every other transition waits
  // for sample_tick. The START state re-checks the line at mid-bit to reject
  // short low glitches. Counting from entry into START, the mid-start point
  // lands on the 8th tick, and each following 16-tick window ends on the
  // middle of the next bit, which is where the data and stop samples are
  // taken. Leaving STOP at the stop-bit middle (rather than its end) gives
  // the next start edge a clean IDLE to land in.
  always_ff @(posedge clk_100MHz or negedge reset_n) begin
    if (!reset_n) begin
      state  <= IDLE;
      s      <= '0;
      n      <= '0;
      shift  <= '0;
      data_q <= '0;
      done_q <= 1'b0;
      ferr_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state)
        IDLE: begin
          if (!rx_s) begin
            state <= START;
            s     <= '0;
          end
        end

        START: begin
          if (sample_tick) begin
            if (s == S_MID) begin
              if (!rx_s) begin
                state <= DATA;
                s     <= '0;
                n     <= '0;
              end else begin
                state <= IDLE;
              end
            end else begin
              s <= s + S_ONE;
            end
          end
        end

        DATA: begin
          if (sample_tick) begin
            if (s == S_LAST_BIT) begin
              s     <= '0;
              // LSB arrives first, so bits enter at the top and walk down.
              shift <= {rx_s, shift[DBITS-1:1]};
              if (n == N_LAST) begin
                state <= STOP;
              end else begin
                n <= n + N_ONE;
              end
            end else begin
              s <= s + S_ONE;
            end
          end
        end

        STOP: begin
          if (sample_tick) begin
            if (s == S_LAST_STOP) begin
              data_q <= shift;
              ferr_q <= ~rx_s;
              done_q <= 1'b1;
              state  <= IDLE;
            end else begin
              s <= s + S_ONE;
            end
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

  assign rx_bus.data_out     = data_q;
  assign rx_bus.rx_done_tick = done_q;
  assign rx_bus.frame_err    = ferr_q;

endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
- UART receive path. Consumes the 16x oversampling `tick` produced by `baud_rate_generator` (default 19,200 baud at 100 MHz) on input `sample_tick`.
- Recovers 8N1 frames from the serial `rx` pin and presents each byte with a one-cycle done strobe and a framing-error flag.
- Sits between the board RX pin and the downstream FIFO/consumer logic.

Parameters:
- DBITS, 8: data bits per frame, LSB first.
- SB_TICK, 16: sample ticks spanning the stop bit(s). 16 = 1 stop bit, 24 = 1.5, 32 = 2.
- OSR, 16: oversampling ratio. Fixed at 16, matching the generator's tick rate.

Ports:
- `clk_100MHz`  in  1  system clock
- `reset_n`  in  1  asynchronous active-low reset
- `rx`  in  1  asynchronous serial input; idle high
- `sample_tick`  in  1  one-cycle pulse at 16x baud, from `baud_rate_generator`
- `data_out`  out  DBITS  last received byte; held until the next frame completes
- `rx_done_tick`  out  1  one-cycle pulse when a frame completes
- `frame_err`  out  1  stop-bit sample was 0 for the frame reported by the latest `rx_done_tick`

Behaviour:
- Clock, reset and timing
  - One clock domain, `clk_100MHz`. Reset is asynchronous, active-low (`reset_n`), and is the only reset.
  - `rx` passes through a 2-FF synchronizer (flops reset to 1) to produce `rx_s`. Synchronizer latency is 2 clocks.
  - All state, counters and outputs change only on `clk_100MHz` edges.
  - Apart from the IDLE start detection, which samples `rx_s` on every clock, the FSM advances only on cycles where `sample_tick` = 1.
- Reset values: state = IDLE, s = 0, n = 0, shift register = 0, `data_out` = 0, `rx_done_tick` = 0, `frame_err` = 0.
- Counters
  - s: 4-bit sample counter. Width is clog2(OSR) for START/DATA and clog2(SB_TICK) in STOP; size the register to the larger.
  - n: data-bit counter of width clog2(DBITS).
- FSM states: IDLE, START, DATA, STOP.
- IDLE: when `rx_s` = 0 (checked every clock, not gated by `sample_tick`), go to START and set s = 0.
- START, on each tick:
  - If s = 7 and `rx_s` = 0: go to DATA with s = 0, n = 0. This is the mid-start-bit point.
  - If s = 7 and `rx_s` = 1: treat as a glitch and return to IDLE. No done pulse.
  - Otherwise s++.
- DATA, on each tick:
  - If s = 15: set s = 0 and shift = {`rx_s`, shift[DBITS-1:1]} (LSB first).
    - If n = DBITS-1, go to STOP.
    - Otherwise n++.
  - Otherwise s++.
- STOP, on each tick:
  - If s = SB_TICK-1, on that edge:
    - `data_out` <= shift
    - `frame_err` <= ~`rx_s`
    - `rx_done_tick` <= 1
    - go to IDLE.
  - Otherwise s++.
- Output timing
  - `rx_done_tick` is registered: high for exactly one clock, the cycle after the final stop tick. It is cleared on every other cycle.
  - A frame with a bad stop bit still pulses `rx_done_tick`, with `frame_err` = 1.
  - `data_out` and `frame_err` are stable from the `rx_done_tick` cycle until the next completion.
- Back-to-back frames: with SB_TICK = 16, IDLE is re-entered about 8 ticks into the stop bit. Detection of the next start edge is immediate; no dead time beyond the return to IDLE.
- `sample_tick` stuck low: the FSM holds its state indefinitely. There is no timeout.
- `rx` held low (break): each tick pattern runs a frame with `data_out` = 0 and `frame_err` = 1, then IDLE immediately restarts.
- Reset mid-frame: all registers return to reset values asynchronously. A partial byte is discarded and no done pulse is issued.

Decomposition:
- Package `uart_pkg` holds:
  - the FSM state enum (IDLE/START/DATA/STOP, 2-bit);
  - OSR = 16;
  - default DBITS and SB_TICK;
  - the mid-bit constant OSR/2-1 = 7.
- One sub-module, `sync_2ff`: a parameterised reset-value synchronizer, reused later by the TX/CTS paths.

Test Plan:
- Reset, then one 8N1 frame carrying 0x55 at 16 ticks/bit (`sample_tick` every 326 clocks) -> single `rx_done_tick` pulse, `data_out` = 0x55, `frame_err` = 0.
- Frame 0xA3 with the stop bit driven 0 -> `rx_done_tick` = 1, `data_out` = 0xA3, `frame_err` = 1. Next good frame 0x3C clears `frame_err` to 0.
- `rx` low glitch lasting 5 ticks, then high -> FSM returns to IDLE; no `rx_done_tick`; `data_out` unchanged.
- Back-to-back frames 0x00 then 0xFF with no idle gap -> two pulses, each exactly one cycle wide, `data_out` = 0x00 then 0xFF, `frame_err` = 0 both times.
- `reset_n` asserted in the middle of data bit 4 of 0xC7, released, then 0x81 sent -> no pulse for the aborted frame; `data_out` = 0 after reset, then 0x81.
- `sample_tick` held low for 10,000 clocks in the middle of a frame, then resumed -> no state advance during the stall; frame completes correctly afterwards.
